// File: rtl/csi_skew.sv
// Stereo skew injector: splits an aligned stereo stream into two channel streams,
// delaying one channel by a programmable number of clocks through a circular buffer.
module csi_skew #(
    parameter int DW       = 16,
    parameter int MAX_SKEW = 64,
    parameter int SKEW_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              skew_sel,
    input  logic [SKEW_W-1:0] skew_dly,
    input  logic              sof_in,
    input  logic              vin,
    input  logic [DW-1:0]     d1_in,
    input  logic [DW-1:0]     d2_in,
    output logic              sof1_out,
    output logic              v1_out,
    output logic [DW-1:0]     d1_out,
    output logic              sof2_out,
    output logic              v2_out,
    output logic [DW-1:0]     d2_out,
    output logic [SKEW_W-1:0] skew_act,
    output logic              run
);

    localparam int AW = $clog2(MAX_SKEW);
    localparam int TW = DW + 2;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic              r_state;
    logic [AW-1:0]     r_wr_ptr;
    logic [SKEW_W-1:0] r_prime;
    logic [SKEW_W-1:0] r_skew_act;
    logic              r_sel;
    logic [TW-1:0]     r_ch1;
    logic [TW-1:0]     r_ch2;
    logic [TW-1:0]     r_mem [MAX_SKEW];

    logic              w_entry;
    logic              w_act;
    logic [SKEW_W-1:0] w_dly_clamp;
    logic [SKEW_W-1:0] w_d;
    logic              w_sel;
    logic [SKEW_W-1:0] w_prime;
    logic [AW-1:0]     w_rd_idx;
    logic [TW-1:0]     w_und;
    logic [TW-1:0]     w_dly_in;
    logic [TW-1:0]     w_dly_raw;
    logic [TW-1:0]     w_und_g;
    logic [TW-1:0]     w_dly_g;

    // The entry cycle already uses the freshly requested delay and channel selection.
    assign w_entry     = (r_state == S_IDLE) & enb & sof_in;
    assign w_act       = (r_state == S_RUN) ? enb : w_entry;
    assign w_dly_clamp = (skew_dly > SKEW_W'(MAX_SKEW)) ? SKEW_W'(MAX_SKEW) : skew_dly;
    assign w_d         = w_entry ? w_dly_clamp : r_skew_act;
    assign w_sel       = w_entry ? skew_sel : r_sel;
    assign w_prime     = w_entry ? '0 : r_prime;
    assign w_rd_idx    = r_wr_ptr - w_d[AW-1:0];

    assign w_und    = w_sel ? {sof_in, vin, d2_in} : {sof_in, vin, d1_in};
    assign w_dly_in = w_sel ? {sof_in, vin, d1_in} : {sof_in, vin, d2_in};

    // D=0 bypasses the buffer; otherwise output is blanked until D samples are stored.
    always_comb begin
        w_dly_raw = '0;
        if (w_d == '0) begin
            w_dly_raw = w_dly_in;
        end else if (w_prime >= w_d) begin
            w_dly_raw = r_mem[w_rd_idx];
        end
        w_und_g = w_und;
        if (!w_und[DW]) begin
            w_und_g[DW-1:0] = '0;
        end
        w_dly_g = w_dly_raw;
        if (!w_dly_raw[DW]) begin
            w_dly_g[DW-1:0] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_act) begin
            r_mem[r_wr_ptr] <= w_dly_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_prime    <= '0;
            r_skew_act <= '0;
            r_sel      <= 1'b0;
            r_ch1      <= '0;
            r_ch2      <= '0;
        end else begin
            if (w_entry) begin
                r_skew_act <= w_dly_clamp;
                r_sel      <= skew_sel;
            end
            if (w_act) begin
                r_state  <= S_RUN;
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_prime  <= (w_prime < w_d) ? w_prime + SKEW_W'(1) : w_prime;
                r_ch1    <= w_sel ? w_dly_g : w_und_g;
                r_ch2    <= w_sel ? w_und_g : w_dly_g;
            end else begin
                r_state <= S_IDLE;
                r_prime <= '0;
                r_ch1   <= '0;
                r_ch2   <= '0;
            end
        end
    end

    assign sof1_out = r_ch1[TW-1];
    assign v1_out   = r_ch1[DW];
    assign d1_out   = r_ch1[DW-1:0];
    assign sof2_out = r_ch2[TW-1];
    assign v2_out   = r_ch2[DW];
    assign d2_out   = r_ch2[DW-1:0];
    assign skew_act = r_skew_act;
    assign run      = (r_state == S_RUN);

endmodule

// File: tb/tb_csi_skew.sv
// Bench for csi_skew: history-based reference model checked every cycle, plus
// literal checks at hand-computed points of each directed scenario.
module tb_csi_skew;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enb = 1'b0;
    logic        skew_sel = 1'b0;
    logic [6:0]  skew_dly = '0;
    logic        sof_in = 1'b0;
    logic        vin = 1'b0;
    logic [15:0] d1_in = '0;
    logic [15:0] d2_in = '0;
    logic        sof1_out, v1_out, sof2_out, v2_out, run;
    logic [15:0] d1_out, d2_out;
    logic [6:0]  skew_act;

    int total = 0;
    int bad = 0;
    logic chk_on = 1'b0;

    csi_skew #(.DW(16), .MAX_SKEW(64), .SKEW_W(7)) dut (
        .clk(clk), .rst(rst), .enb(enb), .skew_sel(skew_sel), .skew_dly(skew_dly),
        .sof_in(sof_in), .vin(vin), .d1_in(d1_in), .d2_in(d2_in),
        .sof1_out(sof1_out), .v1_out(v1_out), .d1_out(d1_out),
        .sof2_out(sof2_out), .v2_out(v2_out), .d2_out(d2_out),
        .skew_act(skew_act), .run(run)
    );

    always #5 clk = ~clk;

    // Reference model: remembers every input sample by cycle number and picks the
    // one D cycles back once D samples have been accepted since entering RUN.
    logic        h_sof [4096];
    logic        h_v   [4096];
    logic [15:0] h_d1  [4096];
    logic [15:0] h_d2  [4096];
    int   cyc = 0;
    int   m_entry = 0;
    int   m_d = 0;
    logic m_sel = 1'b0;
    logic m_run = 1'b0;
    logic [43:0] exp_vec = '0;
    logic [43:0] dut_vec;

    assign dut_vec = {sof1_out, v1_out, d1_out, sof2_out, v2_out, d2_out, skew_act, run};

    always @(posedge clk or posedge rst) begin
        logic        act;
        logic [17:0] und, dly, e1, e2;
        int j;
        if (rst) begin
            m_run = 1'b0;
            m_d = 0;
            m_sel = 1'b0;
            exp_vec = '0;
        end else begin
            act = m_run ? enb : (enb && sof_in);
            if (!m_run && act) begin
                m_d = (skew_dly > 7'd64) ? 64 : int'(skew_dly);
                m_sel = skew_sel;
                m_entry = cyc;
            end
            h_sof[cyc] = sof_in;
            h_v[cyc] = vin;
            h_d1[cyc] = d1_in;
            h_d2[cyc] = d2_in;
            e1 = '0;
            e2 = '0;
            if (act) begin
                und = {sof_in, vin, (vin ? (m_sel ? d2_in : d1_in) : 16'h0)};
                dly = '0;
                if (cyc - m_entry >= m_d) begin
                    j = cyc - m_d;
                    dly = {h_sof[j], h_v[j], (h_v[j] ? (m_sel ? h_d1[j] : h_d2[j]) : 16'h0)};
                end
                e1 = m_sel ? dly : und;
                e2 = m_sel ? und : dly;
                m_run = 1'b1;
            end else begin
                m_run = 1'b0;
            end
            exp_vec = {e1, e2, 7'(m_d), m_run};
            cyc = cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            total = total + 1;
            if (dut_vec !== exp_vec) begin
                bad = bad + 1;
                $display("FAIL model cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick(input logic e, input logic s, input logic v,
                        input logic [15:0] a, input logic [15:0] b);
        enb = e;
        sof_in = s;
        vin = v;
        d1_in = a;
        d2_in = b;
        @(posedge clk);
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        chk_on = 1'b1;
        chk("reset_outs", {7'd0, dut_vec[43:0] == '0}, 32'd1);

        // Enable without sof: data discarded, stays idle.
        tick(1, 0, 1, 16'hDEAD, 16'hBEEF);
        chk("idle_no_sof_run", {31'd0, run}, 32'd0);
        chk("idle_no_sof_v1", {31'd0, v1_out}, 32'd0);

        // Delay ch2 by 5.
        skew_sel = 1'b0;
        skew_dly = 7'd5;
        tick(1, 1, 1, 16'h0100, 16'h1100);
        chk("t2_sof1", {31'd0, sof1_out}, 32'd1);
        chk("t2_d1", {16'd0, d1_out}, 32'h0100);
        chk("t2_run", {31'd0, run}, 32'd1);
        chk("t2_skew_act", {25'd0, skew_act}, 32'd5);
        chk("t2_v2_prime", {31'd0, v2_out}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick(1, 0, 1, 16'h0100 + 16'(i), 16'h1100 + 16'(i));
            if (i == 4) chk("t2_v2_before", {31'd0, v2_out}, 32'd0);
            if (i == 5) begin
                chk("t2_sof2", {31'd0, sof2_out}, 32'd1);
                chk("t2_d2", {16'd0, d2_out}, 32'h1100);
            end
        end
        for (int i = 0; i < 8; i++) tick(1, 0, 0, 16'h0, 16'h0);
        tick(0, 0, 0, 16'h0, 16'h0);

        // Zero delay: both channels identical, latency 1; fills the buffer too.
        skew_dly = 7'd0;
        for (int i = 0; i < 70; i++) begin
            tick(1, i == 0, (i % 7) != 3, 16'h0300 + 16'(i), 16'h0300 + 16'(i));
            if (i == 0) begin
                chk("t3_d2", {16'd0, d2_out}, 32'h0300);
                chk("t3_skew_act", {25'd0, skew_act}, 32'd0);
            end
            chk("t3_same", {15'd0, sof1_out, v1_out, d1_out} ^ {15'd0, sof2_out, v2_out, d2_out}, 32'd0);
        end
        tick(0, 0, 0, 16'h0, 16'h0);

        // Asynchronous reset mid-stream.
        skew_dly = 7'd7;
        for (int i = 0; i < 10; i++) tick(1, i == 0, 1, 16'h0A00 + 16'(i), 16'h0B00 + 16'(i));
        rst = 1'b1;
        #1;
        chk("t1_async_zero", {31'd0, dut_vec == '0}, 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick(1, 0, 1, 16'h0C00, 16'h0D00);
        chk("t1_after_run", {31'd0, run}, 32'd0);
        chk("t1_after_v2", {31'd0, v2_out}, 32'd0);

        // Request 100 on ch1, clamped to 64; buffer holds stale data from earlier runs.
        skew_sel = 1'b1;
        skew_dly = 7'd100;
        for (int i = 0; i < 80; i++) begin
            tick(1, i == 0, 1, 16'h4000 + 16'(i), 16'h5000 + 16'(i));
            if (i == 0) begin
                chk("t4_skew_act", {25'd0, skew_act}, 32'd64);
                chk("t4_d2", {16'd0, d2_out}, 32'h5000);
                chk("t4_v1_prime", {31'd0, v1_out}, 32'd0);
            end
            if (i == 63) chk("t4_v1_before", {31'd0, v1_out}, 32'd0);
            if (i == 64) begin
                chk("t4_sof1", {31'd0, sof1_out}, 32'd1);
                chk("t4_d1", {16'd0, d1_out}, 32'h4000);
            end
        end
        tick(0, 0, 0, 16'h0, 16'h0);

        // Disable mid-frame, re-enable mid-frame, then new frame.
        skew_sel = 1'b0;
        skew_dly = 7'd3;
        for (int i = 0; i < 6; i++) tick(1, i == 0, 1, 16'h6000 + 16'(i), 16'h6100 + 16'(i));
        tick(0, 0, 1, 16'h6006, 16'h6106);
        chk("t5_off_run", {31'd0, run}, 32'd0);
        chk("t5_off_v", {30'd0, v1_out, v2_out}, 32'd0);
        for (int i = 0; i < 4; i++) tick(1, 0, 1, 16'h6007 + 16'(i), 16'h6107 + 16'(i));
        chk("t5_reen_v1", {31'd0, v1_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1, i == 0 || i == 5, i != 5, 16'h7000 + 16'(i), 16'h8000 + 16'(i));
            if (i == 0) begin
                chk("t5_d1", {16'd0, d1_out}, 32'h7000);
                chk("t5_v2_prime", {31'd0, v2_out}, 32'd0);
            end
            if (i == 3) chk("t5_d2", {16'd0, d2_out}, 32'h8000);
        end
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 16'h0, 16'h0);
        tick(0, 0, 0, 16'h0, 16'h0);

        // Delay change during RUN is ignored until the next entry.
        skew_sel = 1'b0;
        skew_dly = 7'd5;
        for (int i = 0; i < 12; i++) begin
            tick(1, i == 0, 1, 16'h8000 + 16'(i), 16'h9000 + 16'(i));
            if (i == 2) begin
                skew_dly = 7'd9;
                skew_sel = 1'b1;
            end
            if (i == 5) chk("t6_d2_old", {16'd0, d2_out}, 32'h9000);
        end
        chk("t6_skew_hold", {25'd0, skew_act}, 32'd5);
        tick(0, 0, 0, 16'h0, 16'h0);
        chk("t6_skew_keep_idle", {25'd0, skew_act}, 32'd5);
        for (int i = 0; i < 14; i++) begin
            tick(1, i == 0, 1, 16'hA000 + 16'(i), 16'hB000 + 16'(i));
            if (i == 0) chk("t6_skew_new", {25'd0, skew_act}, 32'd9);
            if (i == 8) chk("t6_v1_before", {31'd0, v1_out}, 32'd0);
            if (i == 9) chk("t6_d1_new", {16'd0, d1_out}, 32'hA000);
        end
        tick(0, 0, 0, 16'h0, 16'h0);
        tick(0, 0, 0, 16'h0, 16'h0);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
